// File: rtl/connect_port_pkg.sv
// Shared types and defaults for CONNECT router injection ports.
package connect_port_pkg;

  localparam int CP_NUM_VCS    = 2;
  localparam int CP_VC_BITS    = $clog2(CP_NUM_VCS);
  localparam int CP_FLIT_WIDTH = 261;
  localparam int CP_VC_LSB     = 256;
  localparam int VALID_BIT     = CP_FLIT_WIDTH - 1;

  typedef logic [CP_FLIT_WIDTH-1:0] flit_t;
  typedef logic [CP_VC_BITS-1:0]    vc_id_t;

  typedef struct packed {
    logic   valid;
    vc_id_t vc;
  } credit_t;

endpackage

// File: rtl/vc_flit_buffer.sv
// Registered per-VC flit FIFO; full/empty resolved with a maybe_full bit, no flow-through.
module vc_flit_buffer
  import connect_port_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = CP_FLIT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             enq_valid_i,
  output logic             enq_ready_o,
  input  logic [WIDTH-1:0] enq_data_i,
  output logic             deq_valid_o,
  input  logic             deq_ready_i,
  output logic [WIDTH-1:0] deq_data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic             maybe_full_q;
  logic             ptr_eq, full, empty, enq, deq;

  assign ptr_eq      = (wptr_q == rptr_q);
  assign full        = ptr_eq && maybe_full_q;
  assign empty       = ptr_eq && !maybe_full_q;
  assign enq         = enq_valid_i && !full;
  assign deq         = deq_ready_i && !empty;
  assign enq_ready_o = !full;
  assign deq_valid_o = !empty;
  assign deq_data_o  = mem_q[rptr_q];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      if (enq) wptr_q <= wptr_q + PW'(1);
      if (deq) rptr_q <= rptr_q + PW'(1);
      if (enq != deq) maybe_full_q <= enq;
    end
  end

  // Storage carries no reset; occupancy is defined solely by the pointers.
  always_ff @(posedge CLK) begin
    if (enq) mem_q[wptr_q] <= enq_data_i;
  end

endmodule

// File: rtl/multi_vc_in_port.sv
// Device-to-network injection port: per-VC buffers and credits, round-robin send arbitration.
// Optional credit-overflow checking enabled by MULTI_VC_IN_PORT_CREDIT_CHECK_EN.
module multi_vc_in_port
  import connect_port_pkg::*;
#(
  parameter int NUM_VCS    = CP_NUM_VCS,
  parameter int VC_BITS    = $clog2(NUM_VCS),
  parameter int DEPTH      = 8,
  parameter int CREDITS    = 8,
  parameter int FLIT_WIDTH = CP_FLIT_WIDTH,
  parameter int VC_LSB     = CP_VC_LSB
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [FLIT_WIDTH-1:0] put_flit,
  input  logic [VC_BITS-1:0]    put_vc,
  input  logic                  put_flit_valid,
  output logic                  put_flit_ready,
  output logic [FLIT_WIDTH-1:0] send_ports_putFlit_flit_in,
  output logic                  EN_send_ports_putFlit,
  input  logic [VC_BITS:0]      send_ports_getCredits,
  output logic                  EN_send_ports_getCredits,
  output logic                  credit_err
);

  localparam int             CW       = $clog2(CREDITS + 1);
  localparam logic [CW-1:0]  CRED_MAX = CW'(CREDITS);

  logic [NUM_VCS-1:0]    enq_valid, enq_ready, deq_valid, deq_ready;
  logic [NUM_VCS-1:0]    eligible, ret, ovf;
  logic [FLIT_WIDTH-1:0] head [NUM_VCS];
  logic [CW-1:0]         credits_q [NUM_VCS];
  logic [CW-1:0]         credits_d [NUM_VCS];
  logic [VC_BITS-1:0]    last_grant_q, last_grant_d, grant_vc;
  logic                  grant, send;

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign enq_valid[v] = put_flit_valid && (put_vc == VC_BITS'(v));
    assign deq_ready[v] = send && (grant_vc == VC_BITS'(v));
    assign eligible[v]  = deq_valid[v] && (credits_q[v] != '0);
    assign ret[v]       = send_ports_getCredits[VC_BITS] &&
                          (send_ports_getCredits[VC_BITS-1:0] == VC_BITS'(v));

    vc_flit_buffer #(
      .DEPTH(DEPTH),
      .WIDTH(FLIT_WIDTH)
    ) u_buf (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .enq_valid_i(enq_valid[v]),
      .enq_ready_o(enq_ready[v]),
      .enq_data_i (put_flit),
      .deq_valid_o(deq_valid[v]),
      .deq_ready_i(deq_ready[v]),
      .deq_data_o (head[v])
    );
  end

  always_comb begin
    put_flit_ready = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (put_vc == VC_BITS'(v)) put_flit_ready = enq_ready[v];
    end
    if (!RST_N) put_flit_ready = 1'b1;
  end

  // Round-robin: scan from the VC after the last grant, wrapping once around.
  always_comb begin
    grant    = 1'b0;
    grant_vc = last_grant_q;
    for (int i = 1; i <= NUM_VCS; i++) begin
      if (!grant && eligible[(int'(last_grant_q) + i) % NUM_VCS]) begin
        grant    = 1'b1;
        grant_vc = VC_BITS'((int'(last_grant_q) + i) % NUM_VCS);
      end
    end
  end

  assign send         = grant && RST_N;
  assign last_grant_d = send ? grant_vc : last_grant_q;

  always_comb begin
    send_ports_putFlit_flit_in = '0;
    if (send) begin
      send_ports_putFlit_flit_in                      = head[grant_vc];
      send_ports_putFlit_flit_in[FLIT_WIDTH-1]        = 1'b1;
      send_ports_putFlit_flit_in[VC_LSB +: VC_BITS]   = grant_vc;
    end
  end

  assign EN_send_ports_putFlit    = send;
  assign EN_send_ports_getCredits = 1'b1;

  // A send and a return on the same VC cancel; a return at full count saturates.
  always_comb begin
    ovf = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      credits_d[v] = credits_q[v];
      if (deq_ready[v] && !ret[v]) begin
        credits_d[v] = credits_q[v] - CW'(1);
      end else if (ret[v] && !deq_ready[v]) begin
        if (credits_q[v] == CRED_MAX) ovf[v] = 1'b1;
        else                          credits_d[v] = credits_q[v] + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last_grant_q <= VC_BITS'(NUM_VCS - 1);
      for (int v = 0; v < NUM_VCS; v++) credits_q[v] <= CRED_MAX;
    end else begin
      last_grant_q <= last_grant_d;
      for (int v = 0; v < NUM_VCS; v++) credits_q[v] <= credits_d[v];
    end
  end

`ifdef MULTI_VC_IN_PORT_CREDIT_CHECK_EN
  logic credit_err_q;

  always_ff @(posedge CLK) begin
    if (!RST_N)    credit_err_q <= 1'b0;
    else if (|ovf) credit_err_q <= 1'b1;
  end

  assign credit_err = credit_err_q && RST_N;

`ifndef SYNTHESIS
  logic [31:0] cycle_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) cycle_q <= '0;
    else        cycle_q <= cycle_q + 32'd1;
  end

  always @(posedge CLK) begin
    if (RST_N) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (ovf[v]) $error("credit overflow at cycle %0d on VC %0d", cycle_q, v);
      end
    end
  end
`endif
`else
  logic unused_ovf;
  assign unused_ovf = ^ovf;
  assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_multi_vc_in_port.sv
// Self-checking bench for multi_vc_in_port: directed scenarios plus randomized traffic vs a queue model.
module tb_multi_vc_in_port;

  localparam int NV      = 2;
  localparam int VB      = 1;
  localparam int DEPTH   = 8;
  localparam int CREDITS = 8;
  localparam int FW      = 261;
  localparam int VC_LSB  = 256;
`ifdef MULTI_VC_IN_PORT_CREDIT_CHECK_EN
  localparam logic ERR_ON_OVF = 1'b1;
`else
  localparam logic ERR_ON_OVF = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [FW-1:0] put_flit = '0;
  logic [VB-1:0] put_vc = '0;
  logic          put_flit_valid = 1'b0;
  logic          put_flit_ready;
  logic [FW-1:0] flit_out;
  logic          en_out;
  logic [VB:0]   get_credits = '0;
  logic          en_get;
  logic          credit_err;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue and one credit count per VC.
  logic [FW-1:0] mq [NV][$];
  int            mcred [NV];
  int            mlast;
  logic          merr;

  logic          exp_en, exp_ready, exp_err;
  logic [FW-1:0] exp_flit;
  int            exp_g;
  logic          obs_en, obs_ready, obs_err;
  logic [FW-1:0] obs_flit;

  always #5 CLK = ~CLK;

  multi_vc_in_port #(
    .NUM_VCS(NV), .VC_BITS(VB), .DEPTH(DEPTH), .CREDITS(CREDITS),
    .FLIT_WIDTH(FW), .VC_LSB(VC_LSB)
  ) dut (
    .CLK                       (CLK),
    .RST_N                     (RST_N),
    .put_flit                  (put_flit),
    .put_vc                    (put_vc),
    .put_flit_valid            (put_flit_valid),
    .put_flit_ready            (put_flit_ready),
    .send_ports_putFlit_flit_in(flit_out),
    .EN_send_ports_putFlit     (en_out),
    .send_ports_getCredits     (get_credits),
    .EN_send_ports_getCredits  (en_get),
    .credit_err                (credit_err)
  );

  function automatic logic [FW-1:0] rnd_flit();
    logic [287:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return w[FW-1:0];
  endfunction

  function automatic logic [FW-1:0] sent_form(input logic [FW-1:0] f, input int vc);
    logic [FW-1:0] r;
    r = f;
    r[FW-1] = 1'b1;
    r[VC_LSB +: VB] = VB'(vc);
    return r;
  endfunction

  task automatic capture();
    obs_en    = en_out;
    obs_flit  = flit_out;
    obs_ready = put_flit_ready;
    obs_err   = credit_err;
  endtask

  // One clock: drive inputs, predict and capture outputs mid-cycle, then advance the model.
  task automatic cyc(input bit pv, input int pvc, input logic [FW-1:0] pf,
                     input bit cv, input int cvc);
    @(negedge CLK);
    RST_N          = 1'b1;
    put_flit_valid = pv;
    put_vc         = VB'(pvc);
    put_flit       = pf;
    get_credits    = {cv, VB'(cvc)};
    #1;
    exp_ready = (mq[pvc].size() < DEPTH);
    exp_g = -1;
    for (int i = 1; i <= NV; i++) begin
      int idx;
      idx = (mlast + i) % NV;
      if (exp_g < 0 && mq[idx].size() > 0 && mcred[idx] > 0) exp_g = idx;
    end
    exp_en   = (exp_g >= 0);
    exp_flit = '0;
    if (exp_en) exp_flit = sent_form(mq[exp_g][0], exp_g);
    exp_err = merr;
    capture();
    @(posedge CLK);
    if (exp_en) begin
      void'(mq[exp_g].pop_front());
      mcred[exp_g]--;
      mlast = exp_g;
    end
    if (cv && cvc < NV) begin
      if (exp_en && exp_g == cvc) mcred[cvc]++;
      else if (mcred[cvc] == CREDITS) merr = merr | ERR_ON_OVF;
      else mcred[cvc]++;
    end
    if (pv && exp_ready) mq[pvc].push_back(pf);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N          = 1'b0;
    put_flit_valid = 1'b1;
    put_vc         = VB'(1);
    put_flit       = rnd_flit();
    get_credits    = {1'b1, VB'(1)};
    #1;
    capture();
    @(posedge CLK);
    for (int v = 0; v < NV; v++) begin
      mq[v].delete();
      mcred[v] = CREDITS;
    end
    mlast = NV - 1;
    merr  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", obs_ready); end
    checks++; if (obs_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", obs_en); end
    checks++; if (obs_flit !== '0) begin errors++; $display("FAIL reset_flit: got %h want 0", obs_flit); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", obs_err); end
    for (int k = 0; k < 12; k++) cyc(1, 1, rnd_flit(), 0, 0);
    do_reset();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", obs_ready); end
    checks++; if (obs_en !== 1'b0) begin errors++; $display("FAIL midreset_en: got %b want 0", obs_en); end
    checks++; if (obs_flit !== '0) begin errors++; $display("FAIL midreset_flit: got %h want 0", obs_flit); end
    cyc(0, 1, '0, 0, 0);
    checks++; if (obs_en !== 1'b0) begin errors++; $display("FAIL postreset_empty_en: got %b want 0", obs_en); end
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL postreset_ready: got %b want 1", obs_ready); end
    cyc(1, 1, rnd_flit(), 0, 0);
    cyc(0, 0, '0, 0, 0);
    checks++; if (obs_en !== 1'b1) begin errors++; $display("FAIL postreset_credits_en: got %b want 1", obs_en); end
  endtask

  task automatic test_single_vc();
    logic [FW-1:0] f [3];
    do_reset();
    for (int k = 0; k < 3; k++) f[k] = rnd_flit();
    for (int k = 0; k < 6; k++) begin
      cyc(k < 3, 1, (k < 3) ? f[k % 3] : '0, 0, 0);
      checks++;
      if (obs_en !== ((k >= 1 && k <= 3) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL single_en[%0d]: got %b", k, obs_en);
      end
      if (k >= 1 && k <= 3) begin
        checks++;
        if (obs_flit !== sent_form(f[k-1], 1)) begin
          errors++; $display("FAIL single_flit[%0d]: got %h want %h", k, obs_flit, sent_form(f[k-1], 1));
        end
      end
    end
  endtask

  task automatic test_credit_exhaust();
    int sends;
    do_reset();
    sends = 0;
    for (int k = 0; k < 14; k++) begin
      cyc(k < 9, 0, rnd_flit(), 0, 0);
      if (obs_en === 1'b1) sends++;
    end
    checks++; if (sends != 8) begin errors++; $display("FAIL exhaust_sends: got %0d want 8", sends); end
    checks++; if (obs_en !== 1'b0) begin errors++; $display("FAIL exhaust_stall_en: got %b want 0", obs_en); end
    cyc(0, 0, '0, 1, 0);
    checks++; if (obs_en !== 1'b0) begin errors++; $display("FAIL exhaust_ret_same_cycle: got %b want 0", obs_en); end
    cyc(0, 0, '0, 0, 0);
    checks++; if (obs_en !== 1'b1) begin errors++; $display("FAIL exhaust_ret_next_en: got %b want 1", obs_en); end
    checks++; if (obs_flit !== exp_flit) begin errors++; $display("FAIL exhaust_ret_flit: got %h want %h", obs_flit, exp_flit); end
    cyc(0, 0, '0, 0, 0);
    checks++; if (obs_en !== 1'b0) begin errors++; $display("FAIL exhaust_after_en: got %b want 0", obs_en); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 14; k++) cyc(k < 12, 1, rnd_flit(), 0, 0);
    for (int c = 0; c < 7; c++) begin
      cyc(1, 0, rnd_flit(), 1, 1);
      checks++;
      if (obs_en !== (c >= 1 ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL rr_en[%0d]: got %b", c, obs_en);
      end
      if (c >= 1) begin
        checks++;
        if (obs_flit[VC_LSB +: VB] !== VB'((c - 1) % 2)) begin
          errors++; $display("FAIL rr_vc[%0d]: got %0d want %0d", c, obs_flit[VC_LSB +: VB], (c - 1) % 2);
        end
      end
    end
  endtask

  task automatic test_full_buffer();
    logic [FW-1:0] fa;
    do_reset();
    for (int k = 0; k < 17; k++) cyc(k < 16, 1, rnd_flit(), 0, 0);
    cyc(1, 1, rnd_flit(), 0, 0);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL full_ready_vc1: got %b want 0", obs_ready); end
    checks++; if (obs_en !== 1'b0) begin errors++; $display("FAIL full_en: got %b want 0", obs_en); end
    fa = rnd_flit();
    cyc(1, 0, fa, 0, 0);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL full_ready_vc0: got %b want 1", obs_ready); end
    cyc(0, 1, '0, 0, 0);
    checks++; if (obs_en !== 1'b1) begin errors++; $display("FAIL full_vc0_en: got %b want 1", obs_en); end
    checks++; if (obs_flit !== sent_form(fa, 0)) begin errors++; $display("FAIL full_vc0_flit: got %h want %h", obs_flit, sent_form(fa, 0)); end
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL full_still_ready: got %b want 0", obs_ready); end
  endtask

  task automatic test_same_cycle_credit();
    int sends;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      cyc(c < 10, 0, rnd_flit(), c >= 1, 0);
      if (c >= 1) begin
        checks++;
        if (obs_en !== 1'b1) begin errors++; $display("FAIL samecyc_en[%0d]: got %b want 1", c, obs_en); end
      end
    end
    sends = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(k < 9, 0, rnd_flit(), 0, 0);
      if (obs_en === 1'b1) sends++;
    end
    checks++; if (sends != 8) begin errors++; $display("FAIL samecyc_sends: got %0d want 8", sends); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL samecyc_err: got %b want 0", obs_err); end
  endtask

  task automatic test_credit_overflow();
    int sends;
    do_reset();
    cyc(0, 0, '0, 1, 1);
    cyc(0, 0, '0, 0, 0);
    checks++; if (obs_err !== ERR_ON_OVF) begin errors++; $display("FAIL ovf_err: got %b want %b", obs_err, ERR_ON_OVF); end
    sends = 0;
    for (int k = 0; k < 11; k++) begin
      cyc(k < 9, 1, rnd_flit(), 0, 0);
      if (obs_en === 1'b1) sends++;
    end
    checks++; if (sends != 8) begin errors++; $display("FAIL ovf_saturate_sends: got %0d want 8", sends); end
    checks++; if (obs_err !== ERR_ON_OVF) begin errors++; $display("FAIL ovf_err_sticky: got %b want %b", obs_err, ERR_ON_OVF); end
    do_reset();
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL ovf_reset_err: got %b want 0", obs_err); end
    cyc(0, 1, '0, 0, 0);
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL ovf_post_err: got %b want 0", obs_err); end
    checks++; if (obs_en !== 1'b0) begin errors++; $display("FAIL ovf_post_empty: got %b want 0", obs_en); end
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL ovf_post_ready: got %b want 1", obs_ready); end
  endtask

  task automatic test_random();
    bit pv, cv;
    int pvc, cvc;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      pv  = ($urandom % 4) != 0;
      pvc = $urandom % NV;
      cvc = $urandom % NV;
      cv  = (($urandom % 3) == 0) && (mcred[cvc] < CREDITS);
      cyc(pv, pvc, rnd_flit(), cv, cvc);
      checks++; if (obs_en !== exp_en) begin errors++; $display("FAIL rand_en[%0d]: got %b want %b", n, obs_en, exp_en); end
      checks++; if (obs_flit !== exp_flit) begin errors++; $display("FAIL rand_flit[%0d]: got %h want %h", n, obs_flit, exp_flit); end
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", n, obs_ready, exp_ready); end
      checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rand_err[%0d]: got %b want %b", n, obs_err, exp_err); end
    end
    checks++; if (en_get !== 1'b1) begin errors++; $display("FAIL en_getcredits: got %b want 1", en_get); end
  endtask

  initial begin
    test_reset();
    test_single_vc();
    test_credit_exhaust();
    test_round_robin();
    test_full_buffer();
    test_same_cycle_credit();
    test_credit_overflow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
